time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl_pkg.sv | 21 ++
 rtl/time_set_ctrl_bcd_split.sv | 44 ++++
 rtl/time_set_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl_pkg
// Description : Shared state encodings and counter limits for the time-set
//               controller and its helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package time_set_ctrl_pkg;

   // Controller states; the numeric values are visible on the state output.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2
   } state_e;

   localparam logic [4:0] MAX_HR = 5'd23;
   localparam logic [5:0] MAX_MS = 6'd59;

endpackage : time_set_ctrl_pkg
`default_nettype wire

// File: rtl/time_set_ctrl_bcd_split.sv
`default_nettype none
// ============================================================================
// Module      : bcd_split
// Description : Combinational split of a binary 0..59 value into BCD tens
//               and units digits.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_split (
   input  logic [5:0] bin_i,
   output logic [3:0] tens_o,
   output logic [3:0] units_o
);

   logic [5:0] w_rem;

   // Comparator cascade picks the tens digit; the remainder is always < 10.
   always_comb begin
      tens_o = 4'd0;
      w_rem  = bin_i;
      if (bin_i >= 6'd50) begin
         tens_o = 4'd5;
         w_rem  = bin_i - 6'd50;
      end else if (bin_i >= 6'd40) begin
         tens_o = 4'd4;
         w_rem  = bin_i - 6'd40;
      end else if (bin_i >= 6'd30) begin
         tens_o = 4'd3;
         w_rem  = bin_i - 6'd30;
      end else if (bin_i >= 6'd20) begin
         tens_o = 4'd2;
         w_rem  = bin_i - 6'd20;
      end else if (bin_i >= 6'd10) begin
         tens_o = 4'd1;
         w_rem  = bin_i - 6'd10;
      end
      units_o = w_rem[3:0];
   end

   // Upper remainder bits are always zero for legal inputs.
   logic w_unused;
   assign w_unused = ^w_rem[5:4];

endmodule : bcd_split
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : time_set_ctrl
// Description : Clock time-keeping core with a three-state set mode.
//               Keeps hours (binary), minutes (binary, shown as BCD) and
//               seconds; mode/inc pulses allow setting hour and minute.
// Revision    : 1.0 - initial release
// ============================================================================
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter logic [4:0] RESET_HR = 5'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       mode_p,
   input  logic       inc_p,
   output logic [4:0] hr_value,
   output logic [3:0] min1,
   output logic [3:0] min0,
   output logic [5:0] sec,
   output logic [1:0] state,
   output logic       blank_hr,
   output logic       blank_min
);

   state_e     state_q, state_d;
   logic [4:0] hr_q,    hr_d;
   logic [5:0] min_q,   min_d;
   logic [5:0] sec_q,   sec_d;
   logic       blink_q, blink_d;

   // State and counter registers, asynchronously reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         hr_q    <= RESET_HR;
         min_q   <= 6'd0;
         sec_q   <= 6'd0;
         blink_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hr_q    <= hr_d;
         min_q   <= min_d;
         sec_q   <= sec_d;
         blink_q <= blink_d;
      end
   end

   // Next-state logic: mode_p always wins over inc_p; ticks only count in RUN.
   always_comb begin
      state_d = state_q;
      hr_d    = hr_q;
      min_d   = min_q;
      sec_d   = sec_q;
      blink_d = blink_q;
      unique case (state_q)
         RUN: begin
            blink_d = 1'b0;
            if (tick) begin
               if (sec_q == MAX_MS) begin
                  sec_d = 6'd0;
                  if (min_q == MAX_MS) begin
                     min_d = 6'd0;
                     hr_d  = (hr_q == MAX_HR) ? 5'd0 : hr_q + 5'd1;
                  end else begin
                     min_d = min_q + 6'd1;
                  end
               end else begin
                  sec_d = sec_q + 6'd1;
               end
            end
            if (mode_p) state_d = SET_HR;
         end
         SET_HR: begin
            if (tick) blink_d = ~blink_q;
            if (mode_p) begin
               state_d = SET_MIN;
            end else if (inc_p) begin
               hr_d = (hr_q == MAX_HR) ? 5'd0 : hr_q + 5'd1;
            end
         end
         SET_MIN: begin
            if (tick) blink_d = ~blink_q;
            if (mode_p) begin
               // Leaving set mode restarts the minute from second zero.
               state_d = RUN;
               sec_d   = 6'd0;
               blink_d = 1'b0;
            end else if (inc_p) begin
               min_d = (min_q == MAX_MS) ? 6'd0 : min_q + 6'd1;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase
   end

   bcd_split u_bcd_split (
      .bin_i   (min_q),
      .tens_o  (min1),
      .units_o (min0)
   );

   assign hr_value  = hr_q;
   assign sec       = sec_q;
   assign state     = state_q;
   assign blank_hr  = (state_q == SET_HR)  & blink_q;
   assign blank_min = (state_q == SET_MIN) & blink_q;

endmodule : time_set_ctrl
`default_nettype wire
